led_frame_controller: RTL

LED_FRAME_CONTROLLER -- requirements
Module: led_frame_controller

---
 rtl/led_frame_controller.sv | 130 +++++++++++++
 1 files changed

// File: rtl/led_frame_controller.sv
// led_frame_controller: double-buffered LED pixel store that serves a strand driver.
// Frames start on slot-timer ticks, and bank swaps happen only at a frame start.
module led_frame_controller #(
    parameter int NUM_LEDS = 64,
    parameter int FRAME_CYCLES = 1666667,
    localparam int IDX_W = $clog2(NUM_LEDS)
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [23:0]      wr_data,
    input  logic             swap_req,
    input  logic [IDX_W-1:0] next_led_request,
    input  logic             request_valid,
    output logic [7:0]       green_out,
    output logic [7:0]       red_out,
    output logic [7:0]       blue_out,
    output logic             color_valid,
    output logic             force_reset,
    output logic             frame_active,
    output logic             swap_pending,
    output logic [15:0]      frame_count,
    output logic             overrun
);
    localparam int TW = $clog2(FRAME_CYCLES);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t state_q, state_d;
    logic [1:0] sync_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [23:0] pix_q, pix_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic disp_bank_q, disp_bank_d, color_valid_q, color_valid_d, force_reset_q, force_reset_d;
    logic swap_pending_q, swap_pending_d, overrun_q, overrun_d;
    logic [23:0] bank0 [NUM_LEDS];
    logic [23:0] bank1 [NUM_LEDS];
    logic run, tick, in_range, wr_in;
    logic [23:0] rd_data;

    assign run = sync_q[1];
    assign tick = timer_q == TW'(FRAME_CYCLES - 1);
    assign in_range = int'(next_led_request) < NUM_LEDS;
    assign wr_in = wr_en && int'(wr_addr) < NUM_LEDS;
    assign rd_data = !in_range ? 24'h0 : disp_bank_q ? bank1[next_led_request] : bank0[next_led_request];

    assign {green_out, red_out, blue_out} = pix_q;
    assign color_valid = color_valid_q;
    assign force_reset = force_reset_q;
    assign frame_active = state_q == STREAM;
    assign swap_pending = swap_pending_q;
    assign frame_count = frame_count_q;
    assign overrun = overrun_q;

    always_ff @(posedge clk_in) begin
        if (wr_in && disp_bank_q) bank0[wr_addr] <= wr_data;
        if (wr_in && !disp_bank_q) bank1[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else sync_q <= {sync_q[0], 1'b1};
    end

    always_comb begin
        state_d = state_q;
        timer_d = tick ? '0 : timer_q + 1'b1;
        disp_bank_d = disp_bank_q;
        pix_d = pix_q;
        color_valid_d = 1'b0;
        force_reset_d = 1'b0;
        swap_pending_d = swap_pending_q | swap_req;
        frame_count_d = frame_count_q;
        overrun_d = overrun_q;
        if (state_q == IDLE && tick) begin
            state_d = STREAM;
            force_reset_d = 1'b1;
            swap_pending_d = 1'b0;
            disp_bank_d = disp_bank_q ^ (swap_pending_q | swap_req);
        end
        if (state_q == STREAM) begin
            overrun_d = overrun_q | tick;
            if (request_valid) begin
                pix_d = rd_data;
                color_valid_d = 1'b1;
                if (int'(next_led_request) == NUM_LEDS - 1) begin
                    state_d = IDLE;
                    frame_count_d = frame_count_q + 1'b1;
                end
            end
        end
        // Timer preloads the synchronizer latency so the first tick lands FRAME_CYCLES after release
        if (!run) begin
            state_d = IDLE;
            timer_d = TW'(2);
            disp_bank_d = 1'b0;
            pix_d = '0;
            color_valid_d = 1'b0;
            force_reset_d = 1'b0;
            swap_pending_d = 1'b0;
            frame_count_d = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            disp_bank_q <= 1'b0;
            pix_q <= '0;
            color_valid_q <= 1'b0;
            force_reset_q <= 1'b0;
            swap_pending_q <= 1'b0;
            frame_count_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            disp_bank_q <= disp_bank_d;
            pix_q <= pix_d;
            color_valid_q <= color_valid_d;
            force_reset_q <= force_reset_d;
            swap_pending_q <= swap_pending_d;
            frame_count_q <= frame_count_d;
            overrun_q <= overrun_d;
        end
    end
endmodule
